// File: rtl/mcpu_regfile_wb_ctrl.sv
// Write-port controller for MCPU_Registerfile: arbitrates ALU/load write-back and runs a register clear sequence.
// Optional feature: define RR_ARB_EN for round-robin arbitration (default is fixed priority, A over B).
module mcpu_regfile_wb_ctrl #(
  parameter int WORD_SIZE        = 8,
  parameter int OPERAND_SIZE     = 4,
  parameter int REGISTERS_NUMBER = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_start,
  input  logic [WORD_SIZE-1:0]    clr_value,
  output logic                    clr_busy,
  output logic                    clr_done,
  input  logic                    a_req,
  input  logic [OPERAND_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0]    a_data,
  output logic                    a_gnt,
  input  logic                    b_req,
  input  logic [OPERAND_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0]    b_data,
  output logic                    b_gnt,
  output logic [OPERAND_SIZE-1:0] rf_addr,
  output logic [WORD_SIZE-1:0]    rf_data,
  output logic [1:0]              rf_cmd,
  output logic                    rf_wb
);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [OPERAND_SIZE-1:0] LAST_REG = OPERAND_SIZE'(REGISTERS_NUMBER - 1);

  state_t                  state_r, state_s;
  logic [OPERAND_SIZE-1:0] cnt_r, cnt_s;
  logic [WORD_SIZE-1:0]    val_r, val_s;
  logic                    pick_b_s;

  logic                    wb_s, a_gnt_s, b_gnt_s, busy_s, done_s;
  logic [OPERAND_SIZE-1:0] addr_s;
  logic [WORD_SIZE-1:0]    data_s;

`ifdef RR_ARB_EN
  // rr_b_r = 1 means B was not granted last, so B wins a tie
  logic rr_b_r, rr_b_s;
`endif

  // Arbitration winner among the write-back requesters
  always_comb begin
`ifdef RR_ARB_EN
    pick_b_s = b_req && (!a_req || rr_b_r);
`else
    pick_b_s = b_req && !a_req;
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    val_s   = val_r;
    wb_s    = 1'b0;
    a_gnt_s = 1'b0;
    b_gnt_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    addr_s  = {OPERAND_SIZE{1'b0}};
    data_s  = {WORD_SIZE{1'b0}};
`ifdef RR_ARB_EN
    rr_b_s  = rr_b_r;
`endif
    case (state_r)
      SERVE: begin
        if (clr_start) begin
          state_s = CLEAR;
          cnt_s   = {OPERAND_SIZE{1'b0}};
          val_s   = clr_value;
        end else if (pick_b_s) begin
          wb_s    = 1'b1;
          b_gnt_s = 1'b1;
          addr_s  = b_addr;
          data_s  = b_data;
`ifdef RR_ARB_EN
          rr_b_s  = 1'b0;
`endif
        end else if (a_req) begin
          wb_s    = 1'b1;
          a_gnt_s = 1'b1;
          addr_s  = a_addr;
          data_s  = a_data;
`ifdef RR_ARB_EN
          rr_b_s  = 1'b1;
`endif
        end else begin
          wb_s    = 1'b0;
        end
      end
      CLEAR: begin
        wb_s   = 1'b1;
        busy_s = 1'b1;
        addr_s = cnt_r;
        data_s = val_r;
        // compare before increment so the counter never wraps
        if (cnt_r == LAST_REG) begin
          state_s = DONE;
        end else begin
          cnt_s = cnt_r + OPERAND_SIZE'(1);
        end
      end
      DONE: begin
        done_s  = 1'b1;
        state_s = SERVE;
      end
      default: begin
        state_s = SERVE;
      end
    endcase
  end

  // State, counter, latched clear value and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= SERVE;
      cnt_r    <= {OPERAND_SIZE{1'b0}};
      val_r    <= {WORD_SIZE{1'b0}};
      rf_wb    <= 1'b0;
      rf_addr  <= {OPERAND_SIZE{1'b0}};
      rf_data  <= {WORD_SIZE{1'b0}};
      rf_cmd   <= 2'b00;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
`ifdef RR_ARB_EN
      rr_b_r   <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      val_r    <= val_s;
      rf_wb    <= wb_s;
      rf_addr  <= addr_s;
      rf_data  <= data_s;
      rf_cmd   <= 2'b00;
      a_gnt    <= a_gnt_s;
      b_gnt    <= b_gnt_s;
      clr_busy <= busy_s;
      clr_done <= done_s;
`ifdef RR_ARB_EN
      rr_b_r   <= rr_b_s;
`endif
    end
  end

endmodule

// File: tb/tb_mcpu_regfile_wb_ctrl.sv
// Directed self-checking bench for mcpu_regfile_wb_ctrl; per-cycle expected outputs go through a scoreboard queue.
module tb_mcpu_regfile_wb_ctrl;

  logic       clk;
  logic       reset;
  logic       clr_start;
  logic [7:0] clr_value;
  logic       clr_busy, clr_done;
  logic       a_req, b_req;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_gnt, b_gnt;
  logic [3:0] rf_addr;
  logic [7:0] rf_data;
  logic [1:0] rf_cmd;
  logic       rf_wb;

  int n_checks;
  int n_fail;

  // {done, busy, a_gnt, b_gnt, wb, cmd, addr, data}
  logic [18:0] exp_q[$];
  logic        last_b;

  mcpu_regfile_wb_ctrl dut (
    .clk(clk), .reset(reset),
    .clr_start(clr_start), .clr_value(clr_value),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
    .rf_addr(rf_addr), .rf_data(rf_data), .rf_cmd(rf_cmd), .rf_wb(rf_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] pack(input logic done, input logic busy, input logic ag,
                                       input logic bg, input logic wb, input logic [3:0] addr,
                                       input logic [7:0] data);
    return {done, busy, ag, bg, wb, 2'b00, addr, data};
  endfunction

  function automatic logic [18:0] observed();
    return {clr_done, clr_busy, a_gnt, b_gnt, rf_wb, rf_cmd, rf_addr, rf_data};
  endfunction

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [18:0] e);
    exp_q.push_back(e);
  endtask

  // advance one clock and compare the DUT against the oldest scoreboard entry
  task automatic cyc(input string tag);
    logic [18:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, observed());
    end else begin
      e = exp_q.pop_front();
      chk(tag, observed(), e);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push(19'h0);
      cyc(tag);
    end
  endtask

  task automatic clear_seq(input string tag, input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      push(pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i), v));
      cyc(tag);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    last_b    = 1'b1;
    reset     = 1'b1;
    clr_start = 1'b0;
    clr_value = 8'h00;
    a_req = 1'b0; a_addr = 4'h0; a_data = 8'h00;
    b_req = 1'b0; b_addr = 4'h0; b_data = 8'h00;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", observed(), 19'h0);
    reset = 1'b0;
    idle("idle_after_reset", 10);

    // clear sequence; clr_value changes after acceptance and must not leak in
    clr_start = 1'b1;
    clr_value = 8'h0F;
    push(19'h0);
    cyc("clr_accept");
    clr_start = 1'b0;
    clr_value = 8'h55;
    clear_seq("clr_write", 8'h0F, 16);
    push(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00));
    cyc("clr_done_pulse");
    idle("after_clr", 2);

    // single A write
    a_req = 1'b1; a_addr = 4'h3; a_data = 8'hA5;
    push(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 8'hA5));
    cyc("a_single");
    last_b = 1'b0;
    a_req = 1'b0;
    idle("a_single_idle", 1);

    // single B write
    b_req = 1'b1; b_addr = 4'h9; b_data = 8'h3C;
    push(pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 8'h3C));
    cyc("b_single");
    last_b = 1'b1;
    b_req = 1'b0;
    idle("b_single_idle", 1);

    // both requesting continuously; B targets the same register as A
    a_req = 1'b1; a_addr = 4'h6; a_data = 8'h11;
    b_req = 1'b1; b_addr = 4'h6; b_data = 8'h22;
    for (int i = 0; i < 6; i++) begin
`ifdef RR_ARB_EN
      if (last_b) begin
        push(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 8'h11));
      end else begin
        push(pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 8'h22));
      end
      last_b = ~last_b;
`else
      push(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 8'h11));
`endif
      cyc("both_req");
    end
    a_req = 1'b0;
    b_req = 1'b0;
    idle("both_idle", 1);

    // clr_start together with a held a_req: clear first, grant after clr_done
    clr_start = 1'b1;
    clr_value = 8'hC3;
    a_req = 1'b1; a_addr = 4'h5; a_data = 8'h77;
    push(19'h0);
    cyc("clr_vs_a_accept");
    clr_start = 1'b0;
    clear_seq("clr_vs_a_write", 8'hC3, 16);
    push(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00));
    cyc("clr_vs_a_done");
    push(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 8'h77));
    cyc("a_after_clr");
    a_req = 1'b0;
    idle("a_after_clr_idle", 1);

    // reset in the middle of a clear, when rf_addr is 7
    clr_start = 1'b1;
    clr_value = 8'hEE;
    push(19'h0);
    cyc("abort_accept");
    clr_start = 1'b0;
    clear_seq("abort_write", 8'hEE, 8);
    reset = 1'b1;
    #1;
    chk("abort_async", observed(), 19'h0);
    @(posedge clk);
    #1;
    chk("abort_held", observed(), 19'h0);
    reset = 1'b0;
    idle("abort_no_done", 3);
    a_req = 1'b1; a_addr = 4'hE; a_data = 8'h81;
    push(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 8'h81));
    cyc("a_after_abort");
    a_req = 1'b0;
    idle("final_idle", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
